// File: rtl/spo256_allophone_feeder.sv
// Buffers CPC speech bytes in a small FIFO and feeds the allophone codes to an
// SPO256-AL2 one at a time. Each load is paced by the chip's LRQ handshake
// and uses a fixed setup / ALD-low / hold timing sequence.
module spo256_allophone_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int ALD_CYC    = 16,
  parameter int HOLD_CYC   = 4
) (
  input  logic                          iCLK,
  input  logic                          iRESET,
  input  logic                          iSPEECH_WRITE,
  input  logic [7:0]                    iCPC_DATA,
  input  logic                          iSPO_ENABLE,
  input  logic                          i_SPO256__LRQ,
  input  logic                          iCLR_OVERRUN,
  output logic [5:0]                    oSPO_ADR,
  output logic                          o_SPO_ALD,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
  output logic                          oFIFO_FULL,
  output logic                          oFIFO_EMPTY,
  output logic                          oBUSY,
  output logic                          oOVERRUN
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD} state_t;

  logic          r_wr_s1, r_wr_s2, r_wr_s3;
  logic [1:0]    r_wr_prime;
  logic          r_wr_arm;
  logic          r_lrq_s1, r_lrq_s2;
  logic [5:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_full, r_empty, r_ovr;
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [5:0]    r_adr;
  logic          r_ald, r_busy;

  logic          w_push, w_pop, w_wr, w_ovf;
  logic [LW-1:0] w_lvl_nxt;
  logic          w_unused;

  // Top two CPC data bits carry no allophone information.
  assign w_unused = ^iCPC_DATA[7:6];

  // Strobe and LRQ synchronisers. The edge detector is only armed once the
  // synchronised strobe has been genuinely seen low after reset, so a strobe
  // that is already high when reset releases does not count as a write.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_wr_s1    <= 1'b0;
      r_wr_s2    <= 1'b0;
      r_wr_s3    <= 1'b0;
      r_wr_prime <= 2'b00;
      r_wr_arm   <= 1'b0;
      r_lrq_s1   <= 1'b0;
      r_lrq_s2   <= 1'b0;
    end else begin
      r_wr_s1    <= iSPEECH_WRITE;
      r_wr_s2    <= r_wr_s1;
      r_wr_s3    <= r_wr_s2;
      r_wr_prime <= {r_wr_prime[0], 1'b1};
      r_wr_arm   <= r_wr_arm | (r_wr_prime[1] & ~r_wr_s2);
      r_lrq_s1   <= i_SPO256__LRQ;
      r_lrq_s2   <= r_lrq_s1;
    end
  end

  assign w_push = r_wr_s2 & ~r_wr_s3 & r_wr_arm;
  assign w_pop  = (r_state == S_STROBE) && (r_cnt == 8'd0);
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign w_wr   = w_push & (~r_full | w_pop);
  assign w_ovf  = w_push & r_full & ~w_pop;

  // Next fill level from the accepted push and the pop.
  always_comb begin
    w_lvl_nxt = r_level;
    if (w_wr && !w_pop)      w_lvl_nxt = r_level + LW'(1);
    else if (!w_wr && w_pop) w_lvl_nxt = r_level - LW'(1);
  end

  // FIFO storage; only the six address bits are kept.
  always_ff @(posedge iCLK) begin
    if (w_wr && !iRESET) r_mem[r_wptr] <= iCPC_DATA[5:0];
  end

  // Pointers, level and registered full/empty/overrun flags.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_level <= w_lvl_nxt;
      r_full  <= (w_lvl_nxt == LW'(FIFO_DEPTH));
      r_empty <= (w_lvl_nxt == '0);
      if (w_ovf)             r_ovr <= 1'b1;
      else if (iCLR_OVERRUN) r_ovr <= 1'b0;
    end
  end

  // Load sequencer: wait for LRQ, present the address, pulse ALD, hold.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_adr   <= 6'd0;
      r_ald   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ald <= 1'b1;
          if (!r_empty && iSPO_ENABLE) begin
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!r_lrq_s2) begin
            r_adr   <= r_mem[r_rptr];
            r_cnt   <= 8'(SETUP_CYC - 1);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_cnt   <= 8'(ALD_CYC - 1);
            r_ald   <= 1'b0;
            r_state <= S_STROBE;
          end else r_cnt <= r_cnt - 8'd1;
        end
        S_STROBE: begin
          if (r_cnt == 8'd0) begin
            r_ald   <= 1'b1;
            r_cnt   <= 8'(HOLD_CYC - 1);
            r_state <= S_HOLD;
          end else r_cnt <= r_cnt - 8'd1;
        end
        S_HOLD: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else r_cnt <= r_cnt - 8'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ald   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oSPO_ADR    = r_adr;
  assign o_SPO_ALD   = r_ald;
  assign oFIFO_LEVEL = r_level;
  assign oFIFO_FULL  = r_full;
  assign oFIFO_EMPTY = r_empty;
  assign oBUSY       = r_busy;
  assign oOVERRUN    = r_ovr;
endmodule

// File: tb/tb_spo256_allophone_feeder.sv
// Bench for spo256_allophone_feeder: directed scenarios plus randomized bursts,
// checked against a queue-based model of the expected allophone stream.
module tb_spo256_allophone_feeder;
  localparam int DEPTH = 4;
  localparam int ALDC  = 16;

  logic       iCLK = 1'b0;
  logic       iRESET, iSPEECH_WRITE, iSPO_ENABLE, i_SPO256__LRQ, iCLR_OVERRUN;
  logic [7:0] iCPC_DATA;
  logic [5:0] oSPO_ADR;
  logic       o_SPO_ALD, oFIFO_FULL, oFIFO_EMPTY, oBUSY, oOVERRUN;
  logic [2:0] oFIFO_LEVEL;

  spo256_allophone_feeder dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSPEECH_WRITE(iSPEECH_WRITE),
    .iCPC_DATA(iCPC_DATA), .iSPO_ENABLE(iSPO_ENABLE),
    .i_SPO256__LRQ(i_SPO256__LRQ), .iCLR_OVERRUN(iCLR_OVERRUN),
    .oSPO_ADR(oSPO_ADR), .o_SPO_ALD(o_SPO_ALD), .oFIFO_LEVEL(oFIFO_LEVEL),
    .oFIFO_FULL(oFIFO_FULL), .oFIFO_EMPTY(oFIFO_EMPTY), .oBUSY(oBUSY),
    .oOVERRUN(oOVERRUN));

  always #5 iCLK = ~iCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: codes the speech chip should receive, in order.
  logic [5:0] q_exp[$];
  // Observed on the chip pins.
  logic [5:0] q_emit[$];
  int         q_width[$];
  logic       prev_ald = 1'b1;
  int         low_cnt = 0;
  logic [5:0] cur_adr = 6'd0;
  logic       adr_moved = 1'b0;

  // Pin monitor: records each loaded code and every ALD low width.
  always @(negedge iCLK) begin
    if (prev_ald && !o_SPO_ALD) begin
      q_emit.push_back(oSPO_ADR);
      cur_adr = oSPO_ADR;
      low_cnt = 1;
    end else if (!o_SPO_ALD) begin
      low_cnt++;
      if (oSPO_ADR !== cur_adr) adr_moved = 1'b1;
    end else if (!prev_ald) begin
      q_width.push_back(low_cnt);
    end
    prev_ald = o_SPO_ALD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    iCPC_DATA = b;
    iSPEECH_WRITE = 1'b1;
    repeat (2) @(negedge iCLK);
    iSPEECH_WRITE = 1'b0;
    repeat (2) @(negedge iCLK);
  endtask

  task automatic clr_ovr();
    iCLR_OVERRUN = 1'b1;
    @(negedge iCLK);
    iCLR_OVERRUN = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!(oFIFO_EMPTY && !oBUSY) && k < 3000) begin
      @(negedge iCLK);
      k++;
    end
    chk({tag, "_timeout"}, (k < 3000), 1);
  endtask

  task automatic wait_ald(input logic v, input string tag);
    int k = 0;
    while (o_SPO_ALD !== v && k < 300) begin
      @(negedge iCLK);
      k++;
    end
    chk({tag, "_ald_timeout"}, (k < 300), 1);
  endtask

  task automatic cmp_emit(input string tag);
    chk($sformatf("%s_count", tag), q_emit.size(), q_exp.size());
    for (int i = 0; i < q_emit.size() && i < q_exp.size(); i++)
      chk($sformatf("%s_code%0d", tag, i), q_emit[i], q_exp[i]);
    foreach (q_width[i]) chk($sformatf("%s_aldw%0d", tag, i), q_width[i], ALDC);
    chk($sformatf("%s_adr_stable", tag), adr_moved, 0);
    q_emit.delete(); q_exp.delete(); q_width.delete();
  endtask

  logic       s_ald [41];
  logic [5:0] s_adr [41];
  logic [2:0] s_lvl [41];
  logic       s_busy[41];

  initial begin
    int first_lvl, first_busy, first_adr, first_low, last_low, n_low, lvl0, busy_fall;
    int n, mcnt, t;
    logic movr;
    logic [7:0] b;
    logic [5:0] c1, c2;

    iRESET = 1'b1; iSPEECH_WRITE = 1'b0; iCPC_DATA = 8'h00;
    iSPO_ENABLE = 1'b1; i_SPO256__LRQ = 1'b0; iCLR_OVERRUN = 1'b0;
    repeat (3) @(negedge iCLK);
    iRESET = 1'b0;
    @(negedge iCLK);
    chk("rst_level", oFIFO_LEVEL, 0);
    chk("rst_empty", oFIFO_EMPTY, 1);
    chk("rst_full", oFIFO_FULL, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_ovr", oOVERRUN, 0);
    chk("rst_ald", o_SPO_ALD, 1);
    chk("rst_adr", oSPO_ADR, 0);
    repeat (4) @(negedge iCLK);

    // Single write 0x6A with LRQ already low: cycle-accurate timing.
    iCPC_DATA = 8'h6A;
    iSPEECH_WRITE = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge iCLK);
      if (i == 2) iSPEECH_WRITE = 1'b0;
      s_ald[i] = o_SPO_ALD; s_adr[i] = oSPO_ADR;
      s_lvl[i] = oFIFO_LEVEL; s_busy[i] = oBUSY;
    end
    first_lvl = 0; first_busy = 0; first_adr = 0; first_low = 0;
    last_low = 0; n_low = 0; lvl0 = 0; busy_fall = 0;
    for (int i = 1; i <= 40; i++) begin
      if (first_lvl == 0 && s_lvl[i] == 3'd1) first_lvl = i;
      if (first_busy == 0 && s_busy[i]) first_busy = i;
      if (first_adr == 0 && s_adr[i] == 6'h2A) first_adr = i;
      if (!s_ald[i]) begin
        if (first_low == 0) first_low = i;
        last_low = i;
        n_low++;
      end
      if (first_lvl != 0 && lvl0 == 0 && s_lvl[i] == 3'd0) lvl0 = i;
      if (first_busy != 0 && busy_fall == 0 && !s_busy[i]) busy_fall = i;
    end
    chk("t1_push_latency", first_lvl, 3);
    chk("t1_busy_start", first_busy, 4);
    chk("t1_wait_plus_setup", first_low - first_busy, 3);
    chk("t1_setup", first_low - first_adr, 2);
    chk("t1_ald_low_cnt", n_low, 16);
    chk("t1_ald_contig", last_low - first_low, 15);
    chk("t1_adr", (first_low > 0) ? s_adr[first_low] : 6'h3F, 6'h2A);
    chk("t1_pop_on_rise", lvl0, last_low + 1);
    chk("t1_hold", busy_fall - (last_low + 1), 4);
    q_exp.push_back(6'h2A);
    wait_done("t1");
    cmp_emit("t1");

    // Burst of five with LRQ high into a depth-4 FIFO.
    i_SPO256__LRQ = 1'b1;
    repeat (4) @(negedge iCLK);
    for (int i = 1; i <= 5; i++) begin
      wr(8'(i));
      if (i <= DEPTH) q_exp.push_back(6'(i));
    end
    chk("t2_level", oFIFO_LEVEL, 4);
    chk("t2_full", oFIFO_FULL, 1);
    chk("t2_ovr", oOVERRUN, 1);
    chk("t2_busy_wait", oBUSY, 1);
    chk("t2_ald_high", o_SPO_ALD, 1);
    i_SPO256__LRQ = 1'b0;
    wait_done("t2");
    cmp_emit("t2");
    chk("t2_ovr_sticky", oOVERRUN, 1);
    clr_ovr();
    chk("t2_ovr_clr", oOVERRUN, 0);

    // Full FIFO, push lands on the very edge the head is popped.
    i_SPO256__LRQ = 1'b1;
    repeat (4) @(negedge iCLK);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      wr(b);
      q_exp.push_back(b[5:0]);
    end
    chk("t3_full", oFIFO_FULL, 1);
    i_SPO256__LRQ = 1'b0;
    wait_ald(1'b0, "t3");
    repeat (13) @(negedge iCLK);
    b = 8'($urandom);
    iCPC_DATA = b;
    iSPEECH_WRITE = 1'b1;
    repeat (2) @(negedge iCLK);
    iSPEECH_WRITE = 1'b0;
    @(negedge iCLK);
    chk("t3_ald_rose", o_SPO_ALD, 1);
    chk("t3_level", oFIFO_LEVEL, 4);
    chk("t3_ovr", oOVERRUN, 0);
    q_exp.push_back(b[5:0]);
    wait_done("t3");
    cmp_emit("t3");

    // Disable mid-strobe: current load completes, then idle with one left.
    i_SPO256__LRQ = 1'b1;
    repeat (4) @(negedge iCLK);
    c1 = 6'($urandom); c2 = 6'($urandom);
    wr({2'b10, c1}); wr({2'b01, c2});
    q_exp.push_back(c1); q_exp.push_back(c2);
    chk("t4_level2", oFIFO_LEVEL, 2);
    i_SPO256__LRQ = 1'b0;
    wait_ald(1'b0, "t4");
    repeat (3) @(negedge iCLK);
    iSPO_ENABLE = 1'b0;
    t = 0;
    while (oBUSY && t < 100) begin @(negedge iCLK); t++; end
    chk("t4_busy_fall", (t < 100), 1);
    repeat (20) @(negedge iCLK);
    chk("t4_idle", oBUSY, 0);
    chk("t4_level1", oFIFO_LEVEL, 1);
    chk("t4_ald", o_SPO_ALD, 1);
    chk("t4_one_width", q_width.size(), 1);
    iSPO_ENABLE = 1'b1;
    wait_done("t4");
    cmp_emit("t4");

    // LRQ held high for 50 cycles between two codes.
    c1 = 6'($urandom); c2 = 6'($urandom);
    wr({2'b00, c1}); wr({2'b11, c2});
    q_exp.push_back(c1); q_exp.push_back(c2);
    wait_ald(1'b0, "t5a");
    wait_ald(1'b1, "t5b");
    i_SPO256__LRQ = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLK);
      if (!o_SPO_ALD) n++;
    end
    chk("t5_no_ald", n, 0);
    chk("t5_busy", oBUSY, 1);
    chk("t5_level", oFIFO_LEVEL, 1);
    i_SPO256__LRQ = 1'b0;
    n = 0;
    while (o_SPO_ALD && n < 40) begin @(negedge iCLK); n++; end
    chk("t5_lrq_latency", n, 5);
    wait_done("t5");
    cmp_emit("t5");

    // Randomized bursts against the queue model, random LRQ while draining.
    for (int r = 0; r < 6; r++) begin
      i_SPO256__LRQ = 1'b1;
      repeat (4) @(negedge iCLK);
      n = $urandom_range(1, 6);
      mcnt = 0; movr = 1'b0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        wr(b);
        if (mcnt < DEPTH) begin q_exp.push_back(b[5:0]); mcnt++; end
        else movr = 1'b1;
      end
      chk($sformatf("r%0d_level", r), oFIFO_LEVEL, mcnt);
      chk($sformatf("r%0d_full", r), oFIFO_FULL, (mcnt == DEPTH));
      chk($sformatf("r%0d_ovr", r), oOVERRUN, movr);
      clr_ovr();
      chk($sformatf("r%0d_ovr_clr", r), oOVERRUN, 0);
      t = 0;
      while (!(oFIFO_EMPTY && !oBUSY) && t < 3000) begin
        i_SPO256__LRQ = ($urandom_range(0, 3) == 0);
        @(negedge iCLK);
        t++;
      end
      chk($sformatf("r%0d_drain", r), (t < 3000), 1);
      i_SPO256__LRQ = 1'b0;
      cmp_emit($sformatf("r%0d", r));
    end

    // Reset in the middle of an ALD pulse with overrun set.
    i_SPO256__LRQ = 1'b1;
    repeat (4) @(negedge iCLK);
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    chk("t7_ovr_set", oOVERRUN, 1);
    i_SPO256__LRQ = 1'b0;
    wait_ald(1'b0, "t7");
    repeat (3) @(negedge iCLK);
    iRESET = 1'b1;
    iSPEECH_WRITE = 1'b1;
    @(negedge iCLK);
    chk("t7_ald", o_SPO_ALD, 1);
    chk("t7_adr", oSPO_ADR, 0);
    chk("t7_level", oFIFO_LEVEL, 0);
    chk("t7_empty", oFIFO_EMPTY, 1);
    chk("t7_full", oFIFO_FULL, 0);
    chk("t7_busy", oBUSY, 0);
    chk("t7_ovr", oOVERRUN, 0);
    @(negedge iCLK);
    iRESET = 1'b0;
    repeat (6) @(negedge iCLK);
    chk("t7_no_push_high", oFIFO_LEVEL, 0);
    iSPEECH_WRITE = 1'b0;
    repeat (4) @(negedge iCLK);
    chk("t7_no_push_fall", oFIFO_LEVEL, 0);
    chk("t7_still_idle", oBUSY, 0);
    q_emit.delete(); q_width.delete(); q_exp.delete();
    adr_moved = 1'b0;
    wr(8'hFF);
    q_exp.push_back(6'h3F);
    wait_done("t7");
    cmp_emit("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/spo256_allophone_feeder.md
# spo256_allophone_feeder

Clocked stage that consumes speech bytes written by the CPC. The address decoder captures each byte and raises a write strobe; this block buffers the allophone codes in a small FIFO and drives the SPO256-AL2 address lines and active-low ALD strobe. It paces each load with the chip's load-request handshake, so the CPC can write bursts without polling the status port. It also exports FIFO fill state and a sticky overrun flag.

## Interface
Parameters:
- FIFO_DEPTH, 4, allophone FIFO entries; power of two, 2..16
- SETUP_CYC, 2, cycles the address is stable before ALD falls; 1..255
- ALD_CYC, 16, cycles ALD is held low; 1..255
- HOLD_CYC, 4, cycles the address is held after ALD rises; 1..255

Ports:
- iCLK  in  1  system clock; all state changes on its rising edge
- iRESET  in  1  synchronous, active-high reset
- iSPEECH_WRITE  in  1  async write strobe from the decoder, active-high
- iCPC_DATA  in  8  latched CPC byte; stable from the rising edge of iSPEECH_WRITE until the next write
- iSPO_ENABLE  in  1  SPO256 mode active (SSA-1 or DKtronics)
- i_SPO256__LRQ  in  1  async SPO256 load request; low = input buffer can accept a code
- iCLR_OVERRUN  in  1  clears oOVERRUN; synchronous, one-cycle pulse
- oSPO_ADR  out  6  allophone address to SPO256 A6..A1
- o_SPO_ALD  out  1  SPO256 address-load strobe, active-low
- oFIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current entry count
- oFIFO_FULL  out  1  level == FIFO_DEPTH
- oFIFO_EMPTY  out  1  level == 0
- oBUSY  out  1  FSM not in IDLE
- oOVERRUN  out  1  sticky; a write was dropped because the FIFO was full

## Operation
- Input sync: iSPEECH_WRITE passes through 2 flops, then a rising-edge detector (third flop), giving a one-cycle push pulse. i_SPO256__LRQ passes through 2 flops to form lrq_s.
- Push: on a push pulse, store iCPC_DATA[5:0] at the write pointer. Bits 7:6 are discarded. Pushes are accepted regardless of iSPO_ENABLE.
- Push with FIFO full and no pop in the same cycle: drop the byte, set oOVERRUN. Pointers and level are unchanged.
- Push and pop in the same cycle: both take effect and the level is unchanged, including when the FIFO is full. No overrun is flagged.
- Pointers wrap modulo FIFO_DEPTH. The level is tracked separately, so full and empty are unambiguous.
- FSM states, with a single 8-bit down-counter cnt:
  - IDLE: o_SPO_ALD=1. If the FIFO is not empty and iSPO_ENABLE=1, go to WAIT_LRQ.
  - WAIT_LRQ: if lrq_s==0, latch the FIFO head into oSPO_ADR, set cnt=SETUP_CYC-1, go to SETUP. Otherwise remain, with no timeout.
  - SETUP: decrement cnt. At cnt==0, set cnt=ALD_CYC-1, drive o_SPO_ALD=0, go to STROBE.
  - STROBE: o_SPO_ALD=0; decrement cnt. At cnt==0, drive o_SPO_ALD=1, pop the FIFO, set cnt=HOLD_CYC-1, go to HOLD.
  - HOLD: oSPO_ADR is held; decrement cnt. At cnt==0, go to IDLE.
- Disabling iSPO_ENABLE mid-transaction does not truncate the transaction; it completes through HOLD. The FSM then stays in IDLE and the FIFO contents are retained.
- iCLR_OVERRUN and a new overrun in the same cycle: the set wins.
- Reset, including mid-strobe:
  - o_SPO_ALD=1 and oSPO_ADR=0 on the next edge.
  - FIFO emptied (level 0, pointers 0), oFIFO_EMPTY=1, oFIFO_FULL=0.
  - oOVERRUN=0, oBUSY=0, FSM in IDLE.
  - Sync and edge flops cleared. A strobe already high at reset release is not seen as a push.

## Timing
- All outputs are registered.
- Push latency: iSPEECH_WRITE rises before edge E; oFIFO_LEVEL increments after edge E+2.
- From a nonempty FIFO in IDLE with lrq_s already low, edges measured from leaving IDLE:
  - WAIT_LRQ for 1 cycle.
  - oSPO_ADR valid for SETUP_CYC cycles before o_SPO_ALD falls.
  - o_SPO_ALD low for exactly ALD_CYC cycles.
  - oSPO_ADR held HOLD_CYC cycles after o_SPO_ALD rises.
- Minimum per-code period: 2 + SETUP_CYC + ALD_CYC + HOLD_CYC cycles (24 at defaults), plus LRQ wait.
- LRQ latency: 2-cycle sync before it is acted on. LRQ is sampled only in WAIT_LRQ.
- Pop and level decrement occur on the edge o_SPO_ALD rises.

## Test plan
- Reset during STROBE (ALD low) -> o_SPO_ALD=1 next edge, level=0, oBUSY=0, oOVERRUN=0.
- Single write 0x6A, LRQ held low -> oSPO_ADR=0x2A, ALD low exactly 16 cycles, 2-cycle setup and 4-cycle hold; level 1 -> 0 on the ALD rising edge.
- Burst of 5 writes (0x01..0x05) with LRQ high, depth 4 -> level=4, oFIFO_FULL=1, oOVERRUN=1. Release LRQ low -> codes 0x01..0x04 emitted in order, 0x05 never emitted. iCLR_OVERRUN -> oOVERRUN=0.
- FIFO full, push pulse coincident with STROBE-exit pop -> level stays 4, oOVERRUN stays 0, new byte emitted fifth.
- Drop iSPO_ENABLE mid-STROBE with 2 entries queued -> current ALD pulse completes at 16 cycles, FSM idles with level=1. Re-enable -> remaining code emitted.
- LRQ toggled high between codes for 50 cycles -> FSM waits in WAIT_LRQ with ALD high; next load starts 2 sync cycles after LRQ falls.
